// File: rtl/im_port_arbiter.sv
// Instruction-memory read-port arbiter: fetch (port 0) vs debug/loader (port 1), burst-credit fairness.
// Optional build macro IM_ARB_FIXED_PRIO_EN: port 0 always wins a conflict, burst credit disabled.

module im_port_capture #(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              gnt,
  input  logic [DATA_W-1:0] im_instr,
  output logic              rvalid,
  output logic [DATA_W-1:0] rdata
);
  localparam int STAGES = 1;

  logic [STAGES:0] vld_pipe;

  assign vld_pipe[0] = gnt;
  assign rvalid      = vld_pipe[STAGES];

  always_ff @(posedge clk) begin
    if (reset) begin
      vld_pipe[STAGES:1] <= '0;
      rdata              <= '0;
    end else begin
      vld_pipe[STAGES:1] <= vld_pipe[STAGES-1:0];
      if (gnt) rdata <= im_instr;
    end
  end
endmodule

module im_port_arbiter #(
  parameter int ADDR_W = 12,
  parameter int DATA_W = 32,
  parameter int BURST  = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req0,
  input  logic [ADDR_W-1:0] addr0,
  input  logic              req1,
  input  logic [ADDR_W-1:0] addr1,
  output logic [ADDR_W-1:0] im_addr,
  input  logic [DATA_W-1:0] im_instr,
  output logic              gnt0,
  output logic              gnt1,
  output logic              rvalid0,
  output logic [DATA_W-1:0] rdata0,
  output logic              rvalid1,
  output logic [DATA_W-1:0] rdata1,
  output logic              owner
);
  localparam int          NUM_PORTS = 2;
  localparam logic [3:0]  BURST_L   = 4'(BURST);

  typedef enum logic {OWN0 = 1'b0, OWN1 = 1'b1} own_t;

  own_t                                own_q, own_d;
  logic [3:0]                          cnt_q, cnt_d;
  logic [NUM_PORTS-1:0]                req, gnt, rvalid;
  logic [NUM_PORTS-1:0][ADDR_W-1:0]    addr;
  logic [NUM_PORTS-1:0][DATA_W-1:0]    rdata;
  logic                                gnt_port;

  assign req  = {req1, req0};
  assign addr = {addr1, addr0};

  // Grant decision: single requester wins outright; on conflict the owner keeps
  // the port while it still has burst credit.
  always_comb begin
    gnt = '0;
    if (!reset) begin
      unique case (req)
        2'b01:   gnt = 2'b01;
        2'b10:   gnt = 2'b10;
        2'b11: begin
`ifdef IM_ARB_FIXED_PRIO_EN
          gnt = 2'b01;
`else
          if (cnt_q < BURST_L) gnt = (own_q == OWN1) ? 2'b10 : 2'b01;
          else                 gnt = (own_q == OWN1) ? 2'b01 : 2'b10;
`endif
        end
        default: gnt = '0;
      endcase
    end
  end

  assign gnt_port = gnt[1];
  assign im_addr  = gnt[1] ? addr[1] : (gnt[0] ? addr[0] : '0);

  always_comb begin
    own_d = own_q;
    cnt_d = cnt_q;
    if (gnt == '0) begin
      cnt_d = '0;
    end else if (own_t'(gnt_port) == own_q) begin
      if (cnt_q < BURST_L) cnt_d = cnt_q + 4'd1;
    end else begin
      own_d = own_t'(gnt_port);
      cnt_d = 4'd1;
    end
`ifdef IM_ARB_FIXED_PRIO_EN
    cnt_d = '0;
`endif
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      own_q <= OWN0;
      cnt_q <= '0;
    end else begin
      own_q <= own_d;
      cnt_q <= cnt_d;
    end
  end

  for (genvar p = 0; p < NUM_PORTS; p++) begin : g_cap
    im_port_capture #(.DATA_W(DATA_W)) u_cap (
      .clk      (clk),
      .reset    (reset),
      .gnt      (gnt[p]),
      .im_instr (im_instr),
      .rvalid   (rvalid[p]),
      .rdata    (rdata[p])
    );
  end

  assign gnt0    = gnt[0];
  assign gnt1    = gnt[1];
  assign rvalid0 = rvalid[0];
  assign rvalid1 = rvalid[1];
  assign rdata0  = rdata[0];
  assign rdata1  = rdata[1];
  assign owner   = (own_q == OWN1);
endmodule

// File: tb/tb_im_port_arbiter.sv
// Bench for im_port_arbiter: two instances (BURST=4 and BURST=1) sharing stimulus,
// directed vector table, contention sequences, and random traffic against a reference model.

module tb_im_port_arbiter;
  logic        clk = 1'b0;
  logic        reset;
  logic        req0, req1;
  logic [11:0] addr0, addr1;

  logic [11:0] a_ia, b_ia;
  logic [31:0] a_ii, b_ii, a_d0, a_d1, b_d0, b_d1;
  logic        a_g0, a_g1, a_v0, a_v1, a_own;
  logic        b_g0, b_g1, b_v0, b_v1, b_own;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  // memory model: mem[i] = 0x1000_0000 + i
  assign a_ii = 32'h1000_0000 + {20'b0, a_ia};
  assign b_ii = 32'h1000_0000 + {20'b0, b_ia};

  im_port_arbiter #(.ADDR_W(12), .DATA_W(32), .BURST(4)) dut (
    .clk(clk), .reset(reset), .req0(req0), .addr0(addr0), .req1(req1), .addr1(addr1),
    .im_addr(a_ia), .im_instr(a_ii), .gnt0(a_g0), .gnt1(a_g1),
    .rvalid0(a_v0), .rdata0(a_d0), .rvalid1(a_v1), .rdata1(a_d1), .owner(a_own));

  im_port_arbiter #(.ADDR_W(12), .DATA_W(32), .BURST(1)) dut1 (
    .clk(clk), .reset(reset), .req0(req0), .addr0(addr0), .req1(req1), .addr1(addr1),
    .im_addr(b_ia), .im_instr(b_ii), .gnt0(b_g0), .gnt1(b_g1),
    .rvalid0(b_v0), .rdata0(b_d0), .rvalid1(b_v1), .rdata1(b_d1), .owner(b_own));

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h t=%0t", nm, act, exp, $time);
    end
  endtask

  task automatic drive(input logic r, input logic q0, input logic [11:0] a0,
                       input logic q1, input logic [11:0] a1);
    reset = r; req0 = q0; addr0 = a0; req1 = q1; addr1 = a1;
  endtask

  // ---------------- reference model ----------------
  int          bs[2] = '{4, 1};
  logic        m_own[2];
  int          m_run[2];     // consecutive grants held by the current owner
  logic        m_rv[2][2];
  logic [31:0] m_rd[2][2];

  task automatic model_clear();
    for (int d = 0; d < 2; d++) begin
      m_own[d] = 1'b0; m_run[d] = 0;
      for (int p = 0; p < 2; p++) begin m_rv[d][p] = 1'b0; m_rd[d][p] = '0; end
    end
  endtask

  function automatic logic [1:0] m_gnt(input int d);
    logic win;
    if (reset || (!req0 && !req1)) return 2'b00;
    if (req0 && !req1) return 2'b01;
    if (req1 && !req0) return 2'b10;
`ifdef IM_ARB_FIXED_PRIO_EN
    return 2'b01;
`else
    win = (m_run[d] < bs[d]) ? m_own[d] : ~m_own[d];
    return win ? 2'b10 : 2'b01;
`endif
  endfunction

  task automatic model_step(input int d, input logic [1:0] g);
    if (reset) begin
      m_own[d] = 1'b0; m_run[d] = 0;
      for (int p = 0; p < 2; p++) begin m_rv[d][p] = 1'b0; m_rd[d][p] = '0; end
    end else begin
      m_rv[d][0] = g[0];
      m_rv[d][1] = g[1];
      if (g[0]) m_rd[d][0] = 32'h1000_0000 + addr0;
      if (g[1]) m_rd[d][1] = 32'h1000_0000 + addr1;
      if (g == 2'b00)          m_run[d] = 0;
      else if (g[1] == m_own[d]) m_run[d] = (m_run[d] + 1 > bs[d]) ? bs[d] : m_run[d] + 1;
      else begin m_own[d] = g[1]; m_run[d] = 1; end
    end
  endtask

  task automatic chk_model(input int d);
    logic [1:0]  g;
    logic [11:0] ea;
    g  = m_gnt(d);
    ea = g[1] ? addr1 : (g[0] ? addr0 : 12'h000);
    if (d == 0) begin
      chk("rnd4.gnt", {30'b0, a_g1, a_g0}, {30'b0, g});
      chk("rnd4.im_addr", {20'b0, a_ia}, {20'b0, ea});
      chk("rnd4.rvalid", {30'b0, a_v1, a_v0}, {30'b0, m_rv[0][1], m_rv[0][0]});
      chk("rnd4.rdata0", a_d0, m_rd[0][0]);
      chk("rnd4.rdata1", a_d1, m_rd[0][1]);
      chk("rnd4.owner", {31'b0, a_own}, {31'b0, m_own[0]});
    end else begin
      chk("rnd1.gnt", {30'b0, b_g1, b_g0}, {30'b0, g});
      chk("rnd1.im_addr", {20'b0, b_ia}, {20'b0, ea});
      chk("rnd1.rvalid", {30'b0, b_v1, b_v0}, {30'b0, m_rv[1][1], m_rv[1][0]});
      chk("rnd1.rdata0", b_d0, m_rd[1][0]);
      chk("rnd1.rdata1", b_d1, m_rd[1][1]);
      chk("rnd1.owner", {31'b0, b_own}, {31'b0, m_own[1]});
    end
  endtask

  task automatic do_reset();
    drive(1'b1, 1'b0, 12'h0, 1'b0, 12'h0);
    @(posedge clk); #1;
    drive(1'b0, 1'b0, 12'h0, 1'b0, 12'h0);
    model_clear();
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    logic rst; logic q0; logic [11:0] a0; logic q1; logic [11:0] a1;
    logic g0; logic g1; logic [11:0] ia;
    logic v0; logic [31:0] d0; logic v1; logic [31:0] d1; logic own;
  } vec_t;

  vec_t tbl[9];
  logic [7:0] pat;

  initial begin
    tbl[0] = '{1'b0, 1'b1, 12'h004, 1'b0, 12'h000, 1'b1, 1'b0, 12'h004, 1'b0, 32'h0,          1'b0, 32'h0,          1'b0};
    tbl[1] = '{1'b0, 1'b0, 12'h000, 1'b1, 12'h010, 1'b0, 1'b1, 12'h010, 1'b1, 32'h1000_0004, 1'b0, 32'h0,          1'b0};
    tbl[2] = '{1'b0, 1'b0, 12'h000, 1'b0, 12'h000, 1'b0, 1'b0, 12'h000, 1'b0, 32'h1000_0004, 1'b1, 32'h1000_0010, 1'b1};
    tbl[3] = '{1'b0, 1'b1, 12'hFFF, 1'b0, 12'h000, 1'b1, 1'b0, 12'hFFF, 1'b0, 32'h1000_0004, 1'b0, 32'h1000_0010, 1'b1};
    tbl[4] = '{1'b1, 1'b1, 12'h008, 1'b0, 12'h000, 1'b0, 1'b0, 12'h000, 1'b1, 32'h1000_0FFF, 1'b0, 32'h1000_0010, 1'b0};
    tbl[5] = '{1'b0, 1'b0, 12'h000, 1'b0, 12'h000, 1'b0, 1'b0, 12'h000, 1'b0, 32'h0,          1'b0, 32'h0,          1'b0};
    tbl[6] = '{1'b0, 1'b1, 12'h123, 1'b0, 12'h000, 1'b1, 1'b0, 12'h123, 1'b0, 32'h0,          1'b0, 32'h0,          1'b0};
    tbl[7] = '{1'b1, 1'b1, 12'h001, 1'b1, 12'h002, 1'b0, 1'b0, 12'h000, 1'b1, 32'h1000_0123, 1'b0, 32'h0,          1'b0};
    tbl[8] = '{1'b0, 1'b0, 12'h000, 1'b0, 12'h000, 1'b0, 1'b0, 12'h000, 1'b0, 32'h0,          1'b0, 32'h0,          1'b0};

    drive(1'b1, 1'b0, 12'h0, 1'b0, 12'h0);
    repeat (2) @(posedge clk);
    #1;

    for (int i = 0; i < 9; i++) begin
      drive(tbl[i].rst, tbl[i].q0, tbl[i].a0, tbl[i].q1, tbl[i].a1);
      @(negedge clk);
      chk($sformatf("vec%0d.gnt0", i), {31'b0, a_g0}, {31'b0, tbl[i].g0});
      chk($sformatf("vec%0d.gnt1", i), {31'b0, a_g1}, {31'b0, tbl[i].g1});
      chk($sformatf("vec%0d.im_addr", i), {20'b0, a_ia}, {20'b0, tbl[i].ia});
      chk($sformatf("vec%0d.rvalid0", i), {31'b0, a_v0}, {31'b0, tbl[i].v0});
      chk($sformatf("vec%0d.rdata0", i), a_d0, tbl[i].d0);
      chk($sformatf("vec%0d.rvalid1", i), {31'b0, a_v1}, {31'b0, tbl[i].v1});
      chk($sformatf("vec%0d.rdata1", i), a_d1, tbl[i].d1);
      chk($sformatf("vec%0d.owner", i), {31'b0, a_own}, {31'b0, tbl[i].own});
      @(posedge clk); #1;
    end

`ifndef IM_ARB_FIXED_PRIO_EN
    // continuous contention from reset release: BURST=4 -> 0000 1111 ..., BURST=1 -> alternate
    do_reset();
    for (int i = 0; i < 12; i++) begin
      drive(1'b0, 1'b1, 12'h020, 1'b1, 12'h040);
      @(negedge clk);
      chk($sformatf("burst4.c%0d.gnt0", i), {31'b0, a_g0}, {31'b0, ((i / 4) % 2) == 0});
      chk($sformatf("burst4.c%0d.gnt1", i), {31'b0, a_g1}, {31'b0, ((i / 4) % 2) == 1});
      chk($sformatf("burst1.c%0d.gnt1", i), {31'b0, b_g1}, {31'b0, (i % 2) == 1});
      if (i > 0)
        chk($sformatf("burst1.c%0d.owner", i), {31'b0, b_own}, {31'b0, ((i - 1) % 2) == 1});
      @(posedge clk); #1;
    end

    // req1 solo for 2 cycles counts toward its burst credit
    do_reset();
    pat = 8'b0000_1111;
    for (int i = 0; i < 8; i++) begin
      drive(1'b0, i >= 2, 12'h030, 1'b1, 12'h050);
      @(negedge clk);
      chk($sformatf("solo.c%0d.gnt1", i), {31'b0, a_g1}, {31'b0, pat[i]});
      chk($sformatf("solo.c%0d.gnt0", i), {31'b0, a_g0}, {31'b0, ~pat[i]});
      @(posedge clk); #1;
    end
`else
    // fixed priority: port 1 starves under contention
    do_reset();
    for (int i = 0; i < 10; i++) begin
      drive(1'b0, 1'b1, 12'h020, 1'b1, 12'h040);
      @(negedge clk);
      chk($sformatf("fixed.c%0d.gnt0", i), {31'b0, a_g0}, 32'd1);
      chk($sformatf("fixed.c%0d.gnt1", i), {31'b0, a_g1}, 32'd0);
      chk($sformatf("fixed.c%0d.rvalid1", i), {31'b0, a_v1}, 32'd0);
      @(posedge clk); #1;
    end
`endif

    // random traffic vs model, both instances
    do_reset();
    for (int i = 0; i < 600; i++) begin
      logic [1:0] g0m, g1m;
      drive($urandom_range(0, 40) == 0, $urandom_range(0, 9) < 7, 12'($urandom),
            $urandom_range(0, 9) < 7, 12'($urandom));
      @(negedge clk);
      chk_model(0);
      chk_model(1);
      g0m = m_gnt(0);
      g1m = m_gnt(1);
      @(posedge clk);
      model_step(0, g0m);
      model_step(1, g1m);
      #1;
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
